// File: rtl/alu_pkg.sv
// Shared integer-ALU definitions: R-type funct codes and the mult/div sequencer types.
package alu_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_MFHI = 6'h10;
  localparam logic [5:0] FUNCT_MTHI = 6'h11;
  localparam logic [5:0] FUNCT_MFLO = 6'h12;
  localparam logic [5:0] FUNCT_MTLO = 6'h13;
  localparam logic [5:0] FUNCT_MULT = 6'h18;
  localparam logic [5:0] FUNCT_DIV  = 6'h1A;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} md_state_e;
  typedef enum logic {MODE_MUL, MODE_DIV} md_mode_e;

endpackage

// File: rtl/muldiv_step.sv
// One BPC-bit iteration of unsigned shift-add multiply or restoring divide.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  md_mode_e          mode,
  input  logic [WIDTH-1:0]  hw,
  input  logic [WIDTH-1:0]  lw,
  input  logic [WIDTH-1:0]  opd,
  output logic [WIDTH-1:0]  hw_n,
  output logic [WIDTH-1:0]  lw_n
);

  // Multiply: {hw,lw} is {accumulator, multiplier}, shifted right each bit.
  // Divide:   hw is the partial remainder, lw the dividend/quotient shifted left.
  logic [WIDTH:0] t;

  always_comb begin
    hw_n = hw;
    lw_n = lw;
    t    = '0;
    for (int i = 0; i < BPC; i++) begin
      if (mode == MODE_MUL) begin
        t    = {1'b0, hw_n} + (lw_n[0] ? {1'b0, opd} : '0);
        lw_n = {t[0], lw_n[WIDTH-1:1]};
        hw_n = t[WIDTH:1];
      end else begin
        t    = {hw_n, lw_n[WIDTH-1]};
        lw_n = {lw_n[WIDTH-2:0], 1'b0};
        if (t >= {1'b0, opd}) begin
          t       = t - {1'b0, opd};
          lw_n[0] = 1'b1;
        end
        hw_n = t[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative mult/div sequencer owning the architectural HI/LO pair.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_funct,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  md_state_e        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hw, lw, opd;
  logic [WIDTH-1:0] hw_n, lw_n;

  assign req_ready = (state == IDLE) || (state == DONE);

  muldiv_step #(.WIDTH(WIDTH), .BPC(BPC)) u_step (
    .mode (state == DIV ? MODE_DIV : MODE_MUL),
    .hw   (hw),
    .lw   (lw),
    .opd  (opd),
    .hw_n (hw_n),
    .lw_n (lw_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      hw    <= '0;
      lw    <= '0;
      opd   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (req_valid) begin
            case (req_funct)
              FUNCT_MULT: begin
                state <= MUL;
                busy  <= 1'b1;
                cnt   <= '0;
                hw    <= '0;
                lw    <= req_b;
                opd   <= req_a;
              end
              FUNCT_DIV: begin
                if (req_b == '0) begin
                  // Divide by zero skips iteration and commits a fixed result.
                  state <= DONE;
                  done  <= 1'b1;
                  hi    <= req_a;
                  lo    <= '1;
                end else begin
                  state <= DIV;
                  busy  <= 1'b1;
                  cnt   <= '0;
                  hw    <= '0;
                  lw    <= req_a;
                  opd   <= req_b;
                end
              end
              FUNCT_MTHI: hi <= req_a;
              FUNCT_MTLO: lo <= req_a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            hw  <= hw_n;
            lw  <= lw_n;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              // Both modes leave the high half / remainder in hw, low half / quotient in lw.
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              cnt   <= '0;
              hi    <= hw_n;
              lo    <= lw_n;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide sequencer that owns the architectural HI/LO register pair for the integer ALU.
- Accepts mult/div/mthi/mtlo requests from decode over a valid/ready handshake.
- Runs shift-add multiply or restoring divide over WIDTH/BPC cycles.
- Commits HI/LO atomically on completion; the ALU's mfhi/mflo path reads the hi/lo outputs.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- BPC, 1, bits retired per cycle (1, 2 or 4; must divide WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; high in IDLE or DONE.
- req_funct  in  6  18h mult, 1Ah div, 11h mthi, 13h mtlo; all other codes are ignored.
- req_a  in  WIDTH  operand $s (dividend / multiplicand / move source).
- req_b  in  WIDTH  operand $t (divisor / multiplier).
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  MUL or DIV state; decode stalls mfhi/mflo while high.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, done=0, counter and working registers 0. Operation in flight is discarded.
- Accept = req_valid & req_ready on a rising edge; operands and funct captured at that edge. N = WIDTH/BPC.
- States:
  - IDLE: no operation; req_ready=1.
  - MUL: one multiply step per edge.
  - DIV: one divide step per edge.
  - DONE: done=1 for exactly one cycle; req_ready=1.
- Transitions:
  - IDLE/DONE + accept mult -> MUL.
  - IDLE/DONE + accept div with b≠0 -> DIV.
  - IDLE/DONE + accept div with b=0 -> DONE.
  - IDLE/DONE + accept mthi/mtlo/unknown funct -> IDLE.
  - IDLE/DONE + no accept -> IDLE.
  - MUL/DIV with step counter = N-1 -> DONE.
  - MUL/DIV with flush -> IDLE.
- Arithmetic (unsigned):
  - mult: {hi,lo} = a*b, full 2*WIDTH product.
  - div: lo = a/b, hi = a%b.
  - Multiply: shift-add, BPC multiplier bits per edge.
  - Divide: restoring, BPC quotient bits per edge, remainder register WIDTH+1 bits.
- Latency: accept at edge E0; steps on E1..EN; hi/lo written and state->DONE at EN; done high between EN and EN+1. With BPC=1, N=32.
- HI/LO commit: hi/lo change only at the completion edge, or at the mthi/mtlo accept edge. They hold prior values throughout MUL/DIV, so a flushed operation leaves them untouched.
- mthi/mtlo:
  - Write hi (resp. lo) with req_a at the accept edge.
  - The other register is unchanged.
  - No done pulse; busy stays 0.
- Divide by zero:
  - Completes at E1: lo = all ones, hi = a.
  - done pulses at E1..E2; no iteration.
- Unknown funct: accepted (ready handshake completes), no state or register change, no done.
- Back-to-back: an accept while in DONE starts the next operation at the same edge that exits DONE. done still pulses exactly once for the finished operation.
- flush:
  - In MUL/DIV: returns to IDLE next edge, no done, counter cleared.
  - In IDLE/DONE: no effect, except that DONE still drops to IDLE.
  - flush takes priority over completion at the same edge.
- req_ready=0 during MUL/DIV; requests are held off and not queued.
- busy is registered and equals (state==MUL || state==DIV).

Decomposition:
- Shared alu_pkg:
  - funct codes FUNCT_MULT, FUNCT_DIV, FUNCT_MTHI, FUNCT_MTLO, plus the existing ALU funct codes.
  - muldiv state enum {IDLE, MUL, DIV, DONE}.
- One combinational sub-module, muldiv_step: one BPC-bit shift-add or restore-subtract step on the working registers, selected by mode. muldiv_seq instantiates it once and holds FSM, counter and HI/LO.

Test Plan:
- mult a=FFFFFFFFh b=FFFFFFFFh -> after 32 cycles done=1, hi=FFFFFFFEh, lo=00000001h; busy high for exactly 32 cycles.
- div a=100 b=7 -> done at E32, lo=14, hi=2; prior hi/lo values visible unchanged through E31.
- div a=5 b=0 -> done at E1, hi=5, lo=FFFFFFFFh; busy never asserts.
- mthi a=12345678h, then mtlo a=9ABCDEF0h on consecutive edges -> hi=12345678h, lo=9ABCDEF0h, no done; then mult 3*4 issued in DONE cycle of a prior op starts immediately -> lo=12, hi=0.
- mult 7*9 with hi/lo preloaded AAAAh/5555h, flush at E10 -> IDLE at E11, no done, hi=AAAAh, lo=5555h; also assert rst_n=0 mid-DIV at E15 -> hi=lo=0, state IDLE immediately.
- BPC=4 build: mult 0000FFFFh*00010001h -> done at E8, hi=0, lo=FFFFFFFFh; div 0xFFFFFFFF/0x10 -> lo=0FFFFFFFh, hi=Fh at E8.
